// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
//   uart_state_t       : frame state encoding (IDLE..STOP = 0..4), common to TX and RX
//   DATA_BITS          : payload bits per frame
//   OVERSAMPLE_DEFAULT : default clock cycles per bit
//   parity_bit()       : even/odd parity of a data byte
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    // Even parity is the XOR of the data; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a data source and the UART transmitter.
//   TX_Data  : byte to send, held by the source until accepted
//   Valid_tx : TX_Data is valid
//   Ready_tx : transmitter holding buffer is empty
// A transfer happens on any clock edge where Valid_tx & Ready_tx.
interface uart_transmitter_if;

    logic [uart_pkg::DATA_BITS-1:0] TX_Data;
    logic                           Valid_tx;
    logic                           Ready_tx;

    modport master (output TX_Data, output Valid_tx, input Ready_tx);
    modport slave  (input TX_Data, input Valid_tx, output Ready_tx);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running counter 0..OVERSAMPLE-1 with synchronous clear.
//   clk      : clock
//   reset    : synchronous, active-high
//   clear    : synchronous clear, holds the counter at 0
//   bit_done : high in the last cycle of each bit period
module uart_bit_timer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop.
// Each bit lasts exactly OVERSAMPLE clock cycles. A one-entry holding buffer
// lets the next byte be accepted while the current frame is on the line.
//   clk      : clock and bit-timing reference
//   reset    : synchronous, active-high; aborts any frame in progress
//   tx_bus   : byte handshake (TX_Data / Valid_tx / Ready_tx)
//   TXD      : registered serial line, idles high
//   Busy_tx  : high while a frame is on the line
//   Done_tx  : one-cycle pulse in the last cycle of a stop bit
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    uart_transmitter_if.slave   tx_bus,
    output logic                TXD,
    output logic                Busy_tx,
    output logic                Done_tx
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] buf_data;
    logic [DATA_BITS-1:0] shift;
    logic                 buf_full;
    logic [2:0]           bit_index;
    logic                 txd_q;
    logic                 busy_q;
    logic                 bit_done;
    logic                 accept;
    logic                 load;

    // Ready depends only on registered state, never on Valid_tx.
    assign tx_bus.Ready_tx = !buf_full;
    assign accept          = tx_bus.Valid_tx && !buf_full;
    // The shifter is loaded from IDLE or straight out of the last stop cycle.
    assign load            = buf_full && ((state == IDLE) || ((state == STOP) && bit_done));

    assign TXD     = txd_q;
    assign Busy_tx = busy_q;
    assign Done_tx = (state == STOP) && bit_done;

    // Held clear in IDLE so the start bit begins a fresh bit period.
    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            buf_data  <= '0;
            buf_full  <= 1'b0;
            shift     <= '0;
            bit_index <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            if (accept) begin
                buf_data <= tx_bus.TX_Data;
                buf_full <= 1'b1;
            end
            // accept and load are mutually exclusive: load needs a full buffer.
            if (load) begin
                shift     <= buf_data;
                bit_index <= '0;
                buf_full  <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (load) begin
                        state  <= START;
                        txd_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state     <= DATA;
                        bit_index <= '0;
                        txd_q     <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_index == LAST_BIT) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                                txd_q <= parity_bit(shift, PARITY_ODD);
                            end else begin
                                state <= STOP;
                                txd_q <= 1'b1;
                            end
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            txd_q     <= shift[bit_index + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        txd_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (load) begin
                            state <= START;
                            txd_q <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            txd_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
